// File: rtl/tcp_tx_arb_pkg.sv
// Shared types and constants for the SiTCP TX arbiter.
// Optional per-grant header support is enabled with TCP_TX_ARB_HDR_EN.
package tcp_tx_arb_pkg;

  // Width of the per-grant byte counter.
  localparam int unsigned BurstCntW = 12;

  // First byte of every per-grant header.
  localparam logic [7:0] HdrByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArb  = 3'd1,
`ifdef TCP_TX_ARB_HDR_EN
    StHdr0 = 3'd2,
    StHdr1 = 3'd3,
`endif
    StXfer = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: returns the first requester strictly after
// the pointer index, wrapping around. Purely combinational.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx,
  output logic         any
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  // Scan N positions starting one past the pointer; first hit wins.
  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j[IdxW-1:0]]) begin
        any              = 1'b1;
        gnt[j[IdxW-1:0]] = 1'b1;
        idx              = 2'(j);
      end
    end
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Multiplexes up to four byte-stream sources onto the SiTCP TX write port.
// Round-robin grant per frame, forced rotation after MAX_BURST bytes, frame
// abort on connection loss. Define TCP_TX_ARB_HDR_EN to prefix each grant's
// payload with a two-byte header (A5, {00, source, seq}).
module tcp_tx_arbiter
  import tcp_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BURST = 1024
) (
  input  logic                 CLK_200M,
  input  logic                 SYS_RSTn,
  input  logic                 TCP_OPEN_ACK,
  input  logic                 TCP_TX_FULL,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [NUM_SRC-1:0]   src_abort,
  output logic                 TCP_TX_WR,
  output logic [7:0]           TCP_TX_DATA,
  output logic [1:0]           cur_src,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [1:0]           cur_src_q, cur_src_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [BurstCntW-1:0] burst_q, burst_d;
  logic                 wr_q, wr_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_SRC-1:0]   abort_q, abort_d;
`ifdef TCP_TX_ARB_HDR_EN
  logic [NUM_SRC-1:0][3:0] seq_q, seq_d;
`endif

  logic [NUM_SRC-1:0] pick_gnt;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic               unused_pick_gnt;

  logic       link_ok;
  logic       cur_valid;
  logic       cur_last;
  logic [7:0] cur_byte;
  logic       accept;
  logic       burst_end;

  rr_pick #(
    .N (NUM_SRC)
  ) u_rr_pick (
    .req (src_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the index is needed; the one-hot grant is informational.
  assign unused_pick_gnt = ^pick_gnt;

  assign link_ok   = TCP_OPEN_ACK & ~TCP_TX_FULL;
  assign cur_valid = src_valid[cur_src_q];
  assign cur_last  = src_last[cur_src_q];
  assign cur_byte  = src_data[8*cur_src_q +: 8];
  assign accept    = (state_q == StXfer) & link_ok & cur_valid;
  // Compare against MAX_BURST-1 so MAX_BURST=4096 still fits the counter.
  assign burst_end = (burst_q == BurstCntW'(MAX_BURST - 1));

  assign TCP_TX_WR   = wr_q;
  assign TCP_TX_DATA = data_q;
  assign cur_src     = cur_src_q;
  assign src_abort   = abort_q;

  // State register.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (TCP_OPEN_ACK && (|src_req)) state_d = StArb;
      end
      StArb: begin
        if (!TCP_OPEN_ACK || !pick_any) begin
          state_d = StIdle;
        end else begin
`ifdef TCP_TX_ARB_HDR_EN
          state_d = StHdr0;
`else
          state_d = StXfer;
`endif
        end
      end
`ifdef TCP_TX_ARB_HDR_EN
      StHdr0: begin
        if (!TCP_OPEN_ACK)     state_d = StIdle;
        else if (!TCP_TX_FULL) state_d = StHdr1;
      end
      StHdr1: begin
        if (!TCP_OPEN_ACK)     state_d = StIdle;
        else if (!TCP_TX_FULL) state_d = StXfer;
      end
`endif
      StXfer: begin
        if (!TCP_OPEN_ACK)              state_d = StIdle;
        else if (accept && cur_last)    state_d = StIdle;
        else if (accept && burst_end)   state_d = StArb;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath next values, decoded from the current state.
  always_comb begin
    src_ready = '0;
    busy      = (state_q != StIdle);
    wr_d      = 1'b0;
    data_d    = data_q;
    abort_d   = '0;
    cur_src_d = cur_src_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
`ifdef TCP_TX_ARB_HDR_EN
    seq_d     = seq_q;
`endif
    unique case (state_q)
      StIdle: ;
      StArb: begin
        if (TCP_OPEN_ACK && pick_any) begin
          cur_src_d = pick_idx;
          ptr_d     = pick_idx;
          burst_d   = '0;
        end
      end
`ifdef TCP_TX_ARB_HDR_EN
      StHdr0: begin
        if (!TCP_OPEN_ACK) begin
          abort_d[cur_src_q] = 1'b1;
          burst_d            = '0;
        end else if (!TCP_TX_FULL) begin
          wr_d   = 1'b1;
          data_d = HdrByte;
        end
      end
      StHdr1: begin
        if (!TCP_OPEN_ACK) begin
          abort_d[cur_src_q] = 1'b1;
          burst_d            = '0;
        end else if (!TCP_TX_FULL) begin
          wr_d             = 1'b1;
          data_d           = {2'b00, cur_src_q, seq_q[cur_src_q]};
          seq_d[cur_src_q] = seq_q[cur_src_q] + 4'd1;
        end
      end
`endif
      StXfer: begin
        src_ready[cur_src_q] = link_ok;
        if (!TCP_OPEN_ACK) begin
          abort_d[cur_src_q] = 1'b1;
          burst_d            = '0;
        end else if (accept) begin
          wr_d    = 1'b1;
          data_d  = cur_byte;
          burst_d = (cur_last || burst_end) ? '0 : burst_q + BurstCntW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; async reset kills any in-flight write immediately.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      cur_src_q <= '0;
      ptr_q     <= 2'(NUM_SRC - 1);
      burst_q   <= '0;
      wr_q      <= 1'b0;
      data_q    <= 8'h00;
      abort_q   <= '0;
`ifdef TCP_TX_ARB_HDR_EN
      seq_q     <= '0;
`endif
    end else begin
      cur_src_q <= cur_src_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      abort_q   <= abort_d;
`ifdef TCP_TX_ARB_HDR_EN
      seq_q     <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: stimulus pushes the expected
// {source, byte} stream; a monitor pops and compares on every TX write.
module tb_tcp_tx_arbiter;

  localparam int unsigned NSrc     = 4;
  localparam int unsigned MaxBurst = 16;

  logic                CLK_200M = 1'b0;
  logic                SYS_RSTn;
  logic                TCP_OPEN_ACK;
  logic                TCP_TX_FULL;
  logic [NSrc-1:0]     src_req;
  logic [NSrc-1:0]     src_valid;
  logic [8*NSrc-1:0]   src_data;
  logic [NSrc-1:0]     src_last;
  logic [NSrc-1:0]     src_ready;
  logic [NSrc-1:0]     src_abort;
  logic                TCP_TX_WR;
  logic [7:0]          TCP_TX_DATA;
  logic [1:0]          cur_src;
  logic                busy;

  // Per-source pending bytes, bit 8 = last.
  logic [8:0]      sq [NSrc][$];
  // Expected writes, {source, byte}.
  logic [9:0]      exp_q [$];
  logic [NSrc-1:0] hs;
`ifdef TCP_TX_ARB_HDR_EN
  logic [3:0]      seq_m [NSrc];
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK_200M = ~CLK_200M;

  tcp_tx_arbiter #(
    .NUM_SRC   (NSrc),
    .MAX_BURST (MaxBurst)
  ) dut (
    .CLK_200M     (CLK_200M),
    .SYS_RSTn     (SYS_RSTn),
    .TCP_OPEN_ACK (TCP_OPEN_ACK),
    .TCP_TX_FULL  (TCP_TX_FULL),
    .src_req      (src_req),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .src_abort    (src_abort),
    .TCP_TX_WR    (TCP_TX_WR),
    .TCP_TX_DATA  (TCP_TX_DATA),
    .cur_src      (cur_src),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge CLK_200M);
    #2;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic src_frame(input int s, input int base, input int n);
    for (int k = 0; k < n; k++) sq[s].push_back({(k == n - 1), 8'(base + k)});
  endtask

  task automatic exp_grant(input int s, input int base, input int n);
    logic [1:0] s2;
    s2 = 2'(s);
`ifdef TCP_TX_ARB_HDR_EN
    exp_q.push_back({s2, 8'hA5});
    exp_q.push_back({s2, 2'b00, s2, seq_m[s]});
    seq_m[s] = seq_m[s] + 4'd1;
`endif
    for (int k = 0; k < n; k++) exp_q.push_back({s2, 8'(base + k)});
  endtask

  // Returns just after the edge that accepts the n-th byte from source s.
  task automatic wait_hs(input int s, input int n, input string name);
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 300) begin
      @(negedge CLK_200M);
      cyc++;
      if (src_valid[s] && src_ready[s]) cnt++;
    end
    check(name, cnt, n);
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (exp_q.size() == 0 && !busy) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    tick();
    SYS_RSTn = 1'b0;
    for (int s = 0; s < NSrc; s++) begin
      sq[s].delete();
`ifdef TCP_TX_ARB_HDR_EN
      seq_m[s] = 4'd0;
`endif
    end
    tick();
    tick();
    SYS_RSTn = 1'b1;
    tick();
  endtask

  // Source driver: retire handshaken bytes, then present queue heads.
  initial begin
    src_req   = '0;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    hs        = '0;
    forever begin
      @(negedge CLK_200M);
      hs = src_valid & src_ready;
      @(posedge CLK_200M);
      #3;
      for (int i = 0; i < NSrc; i++) begin
        if (hs[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (sq[i].size() > 0) begin
          src_req[i]         = 1'b1;
          src_valid[i]       = 1'b1;
          src_data[8*i +: 8] = sq[i][0][7:0];
          src_last[i]        = sq[i][0][8];
        end else begin
          src_req[i]         = 1'b0;
          src_valid[i]       = 1'b0;
          src_data[8*i +: 8] = 8'h00;
          src_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: every write must match the head of the expected stream.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK_200M);
      if (TCP_TX_WR === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_extra: got src=%0d data=%02h, required no write", cur_src,
                   TCP_TX_DATA);
        end else begin
          e = exp_q.pop_front();
          if ({cur_src, TCP_TX_DATA} !== e) begin
            bad++;
            $display("FAIL tx_byte: got src=%0d data=%02h, required src=%0d data=%02h",
                     cur_src, TCP_TX_DATA, e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_wr;
    int ab_cnt;
    int ab_other;
    SYS_RSTn     = 1'b0;
    TCP_OPEN_ACK = 1'b1;
    TCP_TX_FULL  = 1'b0;
`ifdef TCP_TX_ARB_HDR_EN
    for (int s = 0; s < NSrc; s++) seq_m[s] = 4'd0;
`endif
    repeat (3) tick();

    // Reset values.
    check("rst_wr",    int'(TCP_TX_WR),   0);
    check("rst_data",  int'(TCP_TX_DATA), 0);
    check("rst_ready", int'(src_ready),   0);
    check("rst_abort", int'(src_abort),   0);
    check("rst_cur",   int'(cur_src),     0);
    check("rst_busy",  int'(busy),        0);
    SYS_RSTn = 1'b1;
    tick();

    // Single source 1, five bytes 01..05.
    src_frame(1, 8'h01, 5);
    exp_grant(1, 8'h01, 5);
    wait_drain("single_drain", 100);
    check("single_busy", int'(busy), 0);
    check("single_cur", int'(cur_src), 1);

    // Sources 0 and 2 contend from the reset pointer: order 0, 2, 0.
    do_reset();
    src_frame(0, 8'h10, 3);
    src_frame(2, 8'h20, 2);
    src_frame(0, 8'h30, 4);
    exp_grant(0, 8'h10, 3);
    exp_grant(2, 8'h20, 2);
    exp_grant(0, 8'h30, 4);
    wait_drain("rr_drain", 200);

    // Three-cycle FULL stall after byte 3 of 8.
    do_reset();
    src_frame(2, 8'h40, 8);
    exp_grant(2, 8'h40, 8);
    wait_hs(2, 3, "stall_hs");
    TCP_TX_FULL = 1'b1;
    stall_wr = 0;
    repeat (3) begin
      tick();
      stall_wr += int'(TCP_TX_WR);
    end
    TCP_TX_FULL = 1'b0;
    check("stall_no_wr", stall_wr, 0);
    wait_drain("stall_drain", 100);

    // Forced rotation: 40-byte frame on 0 interleaved with source 1.
    do_reset();
    src_frame(0, 1, 40);
    src_frame(1, 8'h80, 4);
    exp_grant(0, 1, 16);
    exp_grant(1, 8'h80, 4);
    exp_grant(0, 17, 16);
    exp_grant(0, 33, 8);
    wait_drain("burst_drain", 300);

    // Connection drop after byte 2 of 10 on source 3.
    do_reset();
    src_frame(3, 8'h50, 10);
    exp_grant(3, 8'h50, 2);
    wait_hs(3, 2, "abort_hs");
    TCP_OPEN_ACK = 1'b0;
    ab_cnt   = 0;
    ab_other = 0;
    repeat (4) begin
      tick();
      ab_cnt   += int'(src_abort[3]);
      ab_other += int'(|src_abort[2:0]);
    end
    check("abort_pulse", ab_cnt, 1);
    check("abort_other", ab_other, 0);
    check("abort_busy", int'(busy), 0);
    check("abort_written", exp_q.size(), 0);
    sq[3].delete();
    TCP_OPEN_ACK = 1'b1;
    tick();

    // Reset mid-frame clears the pending write at once.
    src_frame(1, 8'h60, 6);
    exp_grant(1, 8'h60, 1);
    wait_hs(1, 2, "midrst_hs");
    SYS_RSTn = 1'b0;
    #1;
    check("midrst_wr", int'(TCP_TX_WR), 0);
    check("midrst_busy", int'(busy), 0);
    for (int s = 0; s < NSrc; s++) begin
      sq[s].delete();
`ifdef TCP_TX_ARB_HDR_EN
      seq_m[s] = 4'd0;
`endif
    end
    tick();
    tick();
    SYS_RSTn = 1'b1;
    tick();

    // Two frames from source 3 (headers A5,30 and A5,31 when enabled).
    src_frame(3, 8'h70, 2);
    src_frame(3, 8'h78, 3);
    exp_grant(3, 8'h70, 2);
    exp_grant(3, 8'h78, 3);
    wait_drain("two_frame_drain", 100);

    repeat (3) tick();
    check("exp_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcp_tx_arbiter.md
TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of byte-stream requesters (legal 2..4).
REQ-002 SHALL have parameter MAX_BURST, default 1024, maximum bytes per grant before forced rotation (legal 16..4096).
REQ-003 SHALL have port CLK_200M  input  1  system clock; all logic in this single domain.
REQ-004 SHALL have port SYS_RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port TCP_OPEN_ACK  input  1  SiTCP connection established.
REQ-006 SHALL have port TCP_TX_FULL  input  1  SiTCP TX almost-full.
REQ-007 SHALL have port src_req  input  NUM_SRC  per-source frame pending.
REQ-008 SHALL have port src_valid  input  NUM_SRC  per-source byte valid.
REQ-009 SHALL have port src_data  input  8*NUM_SRC  per-source byte; source i on bits [8i+7:8i].
REQ-010 SHALL have port src_last  input  NUM_SRC  final byte of the source frame.
REQ-011 SHALL have port src_ready  output  NUM_SRC  byte accepted when valid and ready.
REQ-012 SHALL have port src_abort  output  NUM_SRC  one-cycle pulse: the granted frame was cut by connection loss.
REQ-013 SHALL have port TCP_TX_WR  output  1  write strobe to SiTCP.
REQ-014 SHALL have port TCP_TX_DATA  output  8  write data to SiTCP.
REQ-015 SHALL have port cur_src  output  2  index of the granted source; hold the last value when idle.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL use FSM states IDLE, ARB, (HDR0, HDR1 when configured), XFER.
REQ-018 IDLE->ARB when TCP_OPEN_ACK=1 and any src_req=1.
REQ-019 ARB SHALL grant round-robin: the first requesting index after the last granted index, with wrap; after reset the search starts at index 0; one cycle in ARB.
REQ-020 ARB->XFER when unconfigured; ARB->HDR0 when configured.
REQ-021 In XFER: src_ready[cur_src] = TCP_OPEN_ACK & ~TCP_TX_FULL; every other src_ready bit = 0.
REQ-022 Each accepted byte SHALL appear on TCP_TX_DATA with TCP_TX_WR=1 exactly one cycle later (registered), with no duplication or loss.
REQ-023 TCP_TX_WR SHALL be 0 in every cycle without an accepted byte.
REQ-024 Accepted byte with src_last=1: XFER->IDLE; the burst counter clears.
REQ-025 Burst counter (12 bit) counts accepted bytes; at the MAX_BURST-th byte without last, XFER->ARB (forced rotation, frame continues on a later grant).
REQ-026 TCP_TX_FULL=1 SHALL stall the transfer without changing state; transfer resumes in the cycle after it deasserts.
REQ-027 TCP_OPEN_ACK falling in HDR0/HDR1/XFER: go to IDLE next cycle, pulse src_abort[cur_src], clear burst counter, write no further bytes.
REQ-028 TCP_OPEN_ACK falling in ARB: go to IDLE with no abort pulse.
REQ-029 src_req deasserting after grant SHALL be ignored; only src_last or an abort ends the frame.

Reset
REQ-030 On SYS_RSTn=0: state=IDLE, TCP_TX_WR=0, TCP_TX_DATA=8'h00, src_ready=0, src_abort=0, cur_src=0, busy=0, round-robin pointer=NUM_SRC-1, burst counter=0.
REQ-031 Reset assertion mid-frame SHALL take effect immediately; no partial byte is written afterwards.

Configuration
REQ-032 With macro TCP_TX_ARB_HDR_EN defined: before each grant's payload, emit header byte 8'hA5 (HDR0), then {2'b00, cur_src, seq[3:0]} (HDR1); each byte written only when TCP_TX_FULL=0.
REQ-033 seq SHALL be a per-source 4-bit counter incremented on each completed header, wrapping 15->0, reset to 0.
REQ-034 Without TCP_TX_ARB_HDR_EN: no HDR states, no seq registers, ARB->XFER directly.

Structure
REQ-035 A shared package tcp_tx_arb_pkg SHALL hold the FSM state enum, the header constant 8'hA5 and the burst-counter width.
REQ-036 The round-robin priority picker SHALL be a sub-module rr_pick (combinational request vector plus pointer in, one-hot and index out).

Verification
REQ-037 Single source 1, 5-byte frame 01..05, FULL=0: TX_WR high 5 cycles with data 01..05; busy returns to 0; cur_src=1.
REQ-038 Sources 0 and 2 both requesting, pointer=3: grant order 0, 2, 0 across three frames.
REQ-039 FULL asserted 3 cycles mid-frame after byte 3 of 8: no TX_WR during stall; all 8 bytes delivered in order.
REQ-040 MAX_BURST=16, source 0 sends 40 bytes, source 1 requests: 16 bytes of source 0, then source 1's frame, then source 0 resumes.
REQ-041 TCP_OPEN_ACK dropped after byte 2 of 10: src_abort pulses once for the granted source; no TX_WR after the next cycle; state IDLE.
REQ-042 Macro defined, source 3, two frames: headers A5,30 then A5,31 precede their payloads.
